// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong match sequencer.
// The state enum is 4 bits wide so GAME_OVER fits beside the original eight states.
package pong_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    CLEAR     = 4'd1,
    SERVE     = 4'd2,
    PLAY      = 4'd3,
    PAUSED    = 4'd4,
    POINT_P1  = 4'd5,
    POINT_P2  = 4'd6,
    SETTLE    = 4'd7,
    GAME_OVER = 4'd8
  } match_state_t;

  localparam logic DIR_P1 = 1'b0;
  localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/pong_edge_det.sv
// Rising-edge detector for an already-synchronised button level.
// A RST_VAL of 1 means a button held through reset must be released before it can fire.
module pong_edge_det #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= RST_VAL;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencer: serve countdown, rally, point award, win check, pause and restart.
// Every output is decoded from registered state; serve_dir and winner are flops.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter logic [3:0] WIN_SCORE   = 4'd5,
  parameter int         SERVE_TICKS = 60,
  parameter int         SCORE_LAT   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       frame_tick,
  input  logic       p1_goal,
  input  logic       p2_goal,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic       score_clr,
  output logic       p1_point,
  output logic       p2_point,
  output logic       ball_run,
  output logic       ball_centre,
  output logic       serve_dir,
  output logic       game_over,
  output logic       winner
);

  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_TICKS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SCORE_LAT - 1);

  match_state_t state_q, state_d;
  logic [7:0]   serve_cnt_q, serve_cnt_d;
  logic [3:0]   settle_cnt_q, settle_cnt_d;
  logic         serve_dir_q, serve_dir_d;
  logic         winner_q, winner_d;
  logic         start_rise;
  logic         pause_rise;

  pong_edge_det #(.RST_VAL(1'b1)) u_start_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (start_btn),
    .rise (start_rise)
  );

  pong_edge_det #(.RST_VAL(1'b1)) u_pause_edge (
    .clk  (clk),
    .rst  (rst),
    .in   (pause_btn),
    .rise (pause_rise)
  );

  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt_q;
    settle_cnt_d = settle_cnt_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    case (state_q)
      IDLE: begin
        if (start_rise) state_d = CLEAR;
      end
      CLEAR: begin
        serve_dir_d = DIR_P2;
        serve_cnt_d = 8'd0;
        state_d     = SERVE;
      end
      SERVE: begin
        if (frame_tick) begin
          if (serve_cnt_q == SERVE_LAST) state_d = PLAY;
          else serve_cnt_d = serve_cnt_q + 8'd1;
        end
      end
      PLAY: begin
        // A double goal is a void rally; a goal always beats a same-cycle pause.
        if (p1_goal && p2_goal) begin
          serve_cnt_d = 8'd0;
          state_d     = SERVE;
        end else if (p1_goal) begin
          state_d = POINT_P1;
        end else if (p2_goal) begin
          state_d = POINT_P2;
        end else if (pause_rise) begin
          state_d = PAUSED;
        end
      end
      PAUSED: begin
        if (pause_rise) state_d = PLAY;
      end
      POINT_P1: begin
        serve_dir_d  = DIR_P1;
        settle_cnt_d = 4'd0;
        state_d      = SETTLE;
      end
      POINT_P2: begin
        serve_dir_d  = DIR_P2;
        settle_cnt_d = 4'd0;
        state_d      = SETTLE;
      end
      SETTLE: begin
        // Give the score block SCORE_LAT cycles to absorb the point before sampling.
        if (settle_cnt_q == SETTLE_LAST) begin
          settle_cnt_d = 4'd0;
          if (p1_score >= WIN_SCORE) begin
            winner_d = DIR_P1;
            state_d  = GAME_OVER;
          end else if (p2_score >= WIN_SCORE) begin
            winner_d = DIR_P2;
            state_d  = GAME_OVER;
          end else begin
            serve_cnt_d = 8'd0;
            state_d     = SERVE;
          end
        end else begin
          settle_cnt_d = settle_cnt_q + 4'd1;
        end
      end
      GAME_OVER: begin
        if (start_rise) state_d = CLEAR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      serve_cnt_q  <= 8'd0;
      settle_cnt_q <= 4'd0;
      serve_dir_q  <= DIR_P2;
      winner_q     <= DIR_P1;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
    end
  end

  assign score_clr   = (state_q == CLEAR);
  assign p1_point    = (state_q == POINT_P1);
  assign p2_point    = (state_q == POINT_P2);
  assign ball_run    = (state_q == PLAY);
  assign ball_centre = !((state_q == PLAY) || (state_q == PAUSED));
  assign game_over   = (state_q == GAME_OVER);
  assign serve_dir   = serve_dir_q;
  assign winner      = winner_q;

endmodule
